// File: rtl/cluster_cken_seq_pkg.sv
// rtl/cluster_cken_seq_pkg.sv - state encoding and default delays for the cluster clock/reset sequencer
package cluster_cken_seq_pkg;

    typedef enum logic [2:0] {
        ST_COLD      = 3'd0,
        ST_CKEN_WAIT = 3'd1,
        ST_GRST_WAIT = 3'd2,
        ST_RUN       = 3'd3,
        ST_WARM      = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_STOPPED   = 3'd6,
        ST_RESTART   = 3'd7
    } seq_state_e;

    localparam int DEF_CNT_W     = 4;
    localparam int DEF_CKEN_DLY  = 4;
    localparam int DEF_GRST_DLY  = 8;
    localparam int DEF_DRAIN_DLY = 4;

    // A delay is usable when it is non-zero and its reload value fits the counter.
    function automatic logic dly_legal(input int dly, input int cnt_w);
        return (dly >= 1) && (dly <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/cluster_seq_cnt.sv
// rtl/cluster_seq_cnt.sv - loadable down-counter with zero flag, holds at zero
module cluster_seq_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cluster_cken_seq.sv
// rtl/cluster_cken_seq.sv - per-cluster cken/grst/dbginit sequencer; optional CLUSTER_SEQ_DBGINIT_EN adds dbginit handshake
module cluster_cken_seq
    import cluster_cken_seq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int CKEN_DLY  = DEF_CKEN_DLY,
    parameter int GRST_DLY  = DEF_GRST_DLY,
    parameter int DRAIN_DLY = DEF_DRAIN_DLY
) (
    input  logic       gclk,
    input  logic       arst,
    input  logic       warm_rst_req,
    output logic       warm_rst_ack,
    input  logic       cken_stop_req,
    output logic       cken_stop_ack,
    output logic       cluster_cken,
    output logic       grst_l,
    output logic       gdbginit_l,
`ifdef CLUSTER_SEQ_DBGINIT_EN
    input  logic       dbginit_req,
    output logic       dbginit_ack,
`endif
    output logic [2:0] seq_state
);

    if (!dly_legal(CKEN_DLY, CNT_W)) begin : g_bad_cken_dly
        $error("cluster_cken_seq: CKEN_DLY must be 1..2^CNT_W-1");
    end
    if (!dly_legal(GRST_DLY, CNT_W) || GRST_DLY < 4) begin : g_bad_grst_dly
        $error("cluster_cken_seq: GRST_DLY must be 4..2^CNT_W-1");
    end
    if (!dly_legal(DRAIN_DLY, CNT_W)) begin : g_bad_drain_dly
        $error("cluster_cken_seq: DRAIN_DLY must be 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CKEN_LD  = CNT_W'(CKEN_DLY - 1);
    localparam logic [CNT_W-1:0] GRST_LD  = CNT_W'(GRST_DLY - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_DLY - 1);

    seq_state_e       state_q, state_d;
    logic             cken_q, cken_d;
    logic             grst_q, grst_d;
    logic             dbg_q, dbg_d;
    logic             sack_q, sack_d;
    logic             wack_q, wack_d;
    logic             pend_q, pend_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
`ifdef CLUSTER_SEQ_DBGINIT_EN
    logic             dact_q, dact_d;
    logic             dack_q, dack_d;
`endif

    cluster_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (gclk),
        .rst      (arst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q <= ST_COLD;
            cken_q  <= 1'b0;
            grst_q  <= 1'b0;
            dbg_q   <= 1'b0;
            sack_q  <= 1'b0;
            wack_q  <= 1'b0;
            pend_q  <= 1'b0;
`ifdef CLUSTER_SEQ_DBGINIT_EN
            dact_q  <= 1'b0;
            dack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cken_q  <= cken_d;
            grst_q  <= grst_d;
            dbg_q   <= dbg_d;
            sack_q  <= sack_d;
            wack_q  <= wack_d;
            pend_q  <= pend_d;
`ifdef CLUSTER_SEQ_DBGINIT_EN
            dact_q  <= dact_d;
            dack_q  <= dack_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cken_d   = cken_q;
        grst_d   = grst_q;
        dbg_d    = dbg_q;
        sack_d   = sack_q;
        wack_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        // Warm requests seen outside RUN are remembered and collapse into one.
        pend_d   = pend_q | (warm_rst_req & (state_q != ST_RUN));
`ifdef CLUSTER_SEQ_DBGINIT_EN
        dact_d   = dact_q;
        dack_d   = 1'b0;
`endif

        unique case (state_q)
            ST_COLD: begin
                state_d  = ST_CKEN_WAIT;
                cnt_load = 1'b1;
                cnt_val  = CKEN_LD;
            end
            ST_CKEN_WAIT: begin
                if (cnt_zero) begin
                    state_d  = ST_GRST_WAIT;
                    cken_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = GRST_LD;
                end
            end
            ST_GRST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    grst_d  = 1'b1;
                    dbg_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (pend_q || warm_rst_req) begin
                    state_d  = ST_WARM;
                    grst_d   = 1'b0;
                    dbg_d    = 1'b0;
                    pend_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = GRST_LD;
`ifdef CLUSTER_SEQ_DBGINIT_EN
                    dact_d   = 1'b0;
                end else if (dact_q) begin
                    // Debug init runs inside RUN on the shared counter; stop waits for it.
                    if (cnt_zero) begin
                        dbg_d  = 1'b1;
                        dack_d = 1'b1;
                        dact_d = 1'b0;
                    end
`endif
                end else if (cken_stop_req) begin
                    state_d  = ST_DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = DRAIN_LD;
`ifdef CLUSTER_SEQ_DBGINIT_EN
                end else if (dbginit_req) begin
                    dbg_d    = 1'b0;
                    dact_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = GRST_LD;
`endif
                end
            end
            ST_WARM: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    grst_d  = 1'b1;
                    dbg_d   = 1'b1;
                    wack_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) begin
                    state_d = ST_STOPPED;
                    cken_d  = 1'b0;
                    sack_d  = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (!cken_stop_req) begin
                    state_d  = ST_RESTART;
                    cken_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CKEN_LD;
                end
            end
            ST_RESTART: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    sack_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_COLD;
            end
        endcase
    end

    assign cluster_cken  = cken_q;
    assign grst_l        = grst_q;
    assign gdbginit_l    = dbg_q;
    assign cken_stop_ack = sack_q;
    assign warm_rst_ack  = wack_q;
    assign seq_state     = state_q;
`ifdef CLUSTER_SEQ_DBGINIT_EN
    assign dbginit_ack   = dack_q;
`endif

endmodule
